// File: rtl/occ_arb_pkg.sv
// Shared definitions for the Occ fetch arbiter and the accelerator top.
package occ_arb_pkg;

  // Default Occ memory interface geometry shared with the accelerator top
  localparam int OCC_ADDR_W  = 8;
  localparam int OCC_DATA_W  = 32;
  localparam int OCC_N_LANES = 4;
  localparam int OCC_MAX_OUT = 4;

  // Bit width needed to index 'value' entries, never less than one bit
  function automatic int clog2_min1(input int value);
    int result;
    if (value > 1) begin
      result = $clog2(value);
    end else begin
      result = 1;
    end
    return result;
  endfunction

  // Lane ID width for the default lane count
  localparam int ID_W = clog2_min1(OCC_N_LANES);

endpackage

// File: rtl/occ_id_fifo.sv
// Synchronous FIFO holding the lane IDs of in-flight Occ requests.
// A push is accepted while full as long as a pop happens on the same edge.
module occ_id_fifo
  import occ_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Pointer increment wrapping modulo DEPTH
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_W'(DEPTH - 1)) begin
      nxt = '0;
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == CNT_W'(0));
  assign pop_ok_s  = pop & ~empty_s;
  assign push_ok_s = push & (~full_s | pop_ok_s);

  // ID storage write port
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/occ_fetch_arbiter.sv
// Round-robin arbiter letting N_LANES lane FSMs share one external Occ
// ROM port, with up to MAX_OUT requests in flight and in-order response
// routing back to the issuing lane.
module occ_fetch_arbiter
  import occ_arb_pkg::*;
#(
  parameter int N_LANES = OCC_N_LANES,
  parameter int ADDR_W  = OCC_ADDR_W,
  parameter int DATA_W  = OCC_DATA_W,
  parameter int MAX_OUT = OCC_MAX_OUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      is_start,
  input  logic [N_LANES-1:0]        lane_req_i,
  input  logic [N_LANES*ADDR_W-1:0] lane_addr_i,
  output logic [N_LANES-1:0]        lane_gnt_o,
  output logic [N_LANES-1:0]        lane_rsp_valid_o,
  output logic [DATA_W-1:0]         lane_rsp_data_o,
  output logic                      ce_rom_Occ_o,
  output logic [ADDR_W-1:0]         addr_rom_Occ_o,
  input  logic [DATA_W-1:0]         data_Occ_i,
  input  logic                      data_Occ_valid_i,
  output logic                      busy_o,
  output logic                      err_spurious_o
);

  localparam int LID_W = clog2_min1(N_LANES);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  logic [LID_W-1:0]   ptr_r;
  logic [LID_W-1:0]   sel_s;
  logic [LID_W-1:0]   head_s;
  logic               found_s;
  logic               can_issue_s;
  logic               grant_s;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CNT_W-1:0]   count_s;
  logic [N_LANES-1:0] gnt_s;
  logic [N_LANES-1:0] head_oh_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic               ce_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [N_LANES-1:0] rsp_valid_r;
  logic [DATA_W-1:0]  rsp_data_r;
  logic               err_r;

  // A pop frees a slot on the same edge, so a full FIFO can still issue
  assign pop_s       = data_Occ_valid_i & ~fifo_empty_s;
  assign can_issue_s = rst_n & is_start & (~fifo_full_s | pop_s);
  assign grant_s     = found_s & can_issue_s;

  // Round-robin search: first requesting lane at or after the pointer
  always_comb begin
    int idx;
    idx     = 0;
    found_s = 1'b0;
    sel_s   = '0;
    for (int i = 0; i < N_LANES; i++) begin
      idx = int'(ptr_r) + i;
      if (idx >= N_LANES) begin
        idx = idx - N_LANES;
      end else begin
        idx = idx;
      end
      if (!found_s && lane_req_i[LID_W'(idx)]) begin
        found_s = 1'b1;
        sel_s   = LID_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant and address mux for the selected lane
  always_comb begin
    gnt_s      = '0;
    sel_addr_s = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (sel_s == LID_W'(k)) begin
        gnt_s[k]   = grant_s;
        sel_addr_s = lane_addr_i[k*ADDR_W +: ADDR_W];
      end else begin
        gnt_s[k]   = 1'b0;
      end
    end
  end

  // One-hot decode of the lane owning the oldest outstanding request
  always_comb begin
    head_oh_s = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (head_s == LID_W'(k)) begin
        head_oh_s[k] = 1'b1;
      end else begin
        head_oh_s[k] = 1'b0;
      end
    end
  end

  occ_id_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (LID_W)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant_s),
    .pop   (pop_s),
    .din   (sel_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count_s),
    .head  (head_s)
  );

  // Issue side: external strobe, address and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_r   <= 1'b0;
      addr_r <= '0;
      ptr_r  <= '0;
    end else if (grant_s) begin
      ce_r   <= 1'b1;
      addr_r <= sel_addr_s;
      if (sel_s == LID_W'(N_LANES - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= sel_s + LID_W'(1);
      end
    end else begin
      ce_r   <= 1'b0;
    end
  end

  // Response side: route popped data to its lane, flag responses with nothing outstanding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
      err_r       <= 1'b0;
    end else begin
      if (pop_s) begin
        rsp_valid_r <= head_oh_s;
        rsp_data_r  <= data_Occ_i;
      end else begin
        rsp_valid_r <= '0;
      end
      if (data_Occ_valid_i && fifo_empty_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign lane_gnt_o       = gnt_s;
  assign lane_rsp_valid_o = rsp_valid_r;
  assign lane_rsp_data_o  = rsp_data_r;
  assign ce_rom_Occ_o     = ce_r;
  assign addr_rom_Occ_o   = addr_r;
  assign busy_o           = (count_s != CNT_W'(0));
  assign err_spurious_o   = err_r;

endmodule

// File: tb/tb_occ_fetch_arbiter.sv
// Directed bench for occ_fetch_arbiter with a response scoreboard.
module tb_occ_fetch_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int MO  = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            is_start;
  logic [N-1:0]    lane_req_i;
  logic [N*AW-1:0] lane_addr_i;
  logic [N-1:0]    lane_gnt_o;
  logic [N-1:0]    lane_rsp_valid_o;
  logic [DW-1:0]   lane_rsp_data_o;
  logic            ce_rom_Occ_o;
  logic [AW-1:0]   addr_rom_Occ_o;
  logic [DW-1:0]   data_Occ_i;
  logic            data_Occ_valid_i;
  logic            busy_o;
  logic            err_spurious_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ce_cnt = 0;

  int            exp_lane_q [$];
  logic [DW-1:0] exp_data_q [$];
  logic [AW-1:0] exp_addr_q [$];
  logic [AW-1:0] mem_addr_q [$];
  int            mem_due_q  [$];
  bit            mem_auto = 1'b0;
  logic [DW-1:0] last_data = '0;

  always #5 clk = ~clk;

  occ_fetch_arbiter #(.N_LANES(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .is_start         (is_start),
    .lane_req_i       (lane_req_i),
    .lane_addr_i      (lane_addr_i),
    .lane_gnt_o       (lane_gnt_o),
    .lane_rsp_valid_o (lane_rsp_valid_o),
    .lane_rsp_data_o  (lane_rsp_data_o),
    .ce_rom_Occ_o     (ce_rom_Occ_o),
    .addr_rom_Occ_o   (addr_rom_Occ_o),
    .data_Occ_i       (data_Occ_i),
    .data_Occ_valid_i (data_Occ_valid_i),
    .busy_o           (busy_o),
    .err_spurious_o   (err_spurious_o)
  );

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {8'hA5, 8'h3C, a, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_valid(input logic [DW-1:0] d);
    data_Occ_valid_i = 1'b1;
    data_Occ_i       = d;
    exp_data_q.push_back(d);
  endtask

  // One clock: optional memory model, grant capture, edge, scoreboard checks
  task automatic cycle();
    logic [N-1:0]  g;
    logic [DW-1:0] ed;
    logic [AW-1:0] ma;
    int            el;
    int            due;
    if (mem_auto && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      ma  = mem_addr_q.pop_front();
      due = mem_due_q.pop_front();
      drive_valid(mem_data(ma));
    end
    #1;
    g = lane_gnt_o & lane_req_i;
    for (int k = 0; k < N; k++) begin
      if (g[k]) begin
        exp_lane_q.push_back(k);
        exp_addr_q.push_back(lane_addr_i[k*AW +: AW]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    data_Occ_valid_i = 1'b0;
    if (ce_rom_Occ_o) begin
      ce_cnt++;
      if (exp_addr_q.size() == 0) chk("ce_unexpected", {63'd0, ce_rom_Occ_o}, 64'd0);
      else chk("ce_addr", addr_rom_Occ_o, exp_addr_q.pop_front());
      if (mem_auto) begin
        mem_addr_q.push_back(addr_rom_Occ_o);
        mem_due_q.push_back(cyc + LAT - 1);
      end
    end
    if (lane_rsp_valid_o != '0) begin
      if (exp_lane_q.size() == 0 || exp_data_q.size() == 0) begin
        chk("rsp_unexpected", lane_rsp_valid_o, 64'd0);
      end else begin
        el = exp_lane_q.pop_front();
        ed = exp_data_q.pop_front();
        chk("rsp_lane", lane_rsp_valid_o, oh(el));
        chk("rsp_data", lane_rsp_data_o, ed);
        last_data = ed;
      end
    end
  endtask

  task automatic clear_sb();
    exp_lane_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    lane_req_i = '0;
    cycle();
    rst_n = 1'b1;
    clear_sb();
    last_data = '0;
  endtask

  initial begin
    rst_n            = 1'b0;
    is_start         = 1'b1;
    lane_req_i       = 4'b0001;
    lane_addr_i      = {8'h13, 8'h12, 8'h11, 8'h12};
    data_Occ_i       = '0;
    data_Occ_valid_i = 1'b0;

    // Reset state, grants held off while in reset
    #1;
    chk("gnt_in_reset", lane_gnt_o, 4'b0000);
    cycle();
    cycle();
    lane_req_i = '0;
    chk("rst_ce", ce_rom_Occ_o, 1'b0);
    chk("rst_addr", addr_rom_Occ_o, 8'h00);
    chk("rst_rsp_valid", lane_rsp_valid_o, 4'b0000);
    chk("rst_rsp_data", lane_rsp_data_o, 32'h0);
    chk("rst_err", err_spurious_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    clear_sb();

    // Single lane 0 fetch of 0x12, response DEADBEEF
    lane_req_i = 4'b0001;
    #1;
    chk("t1_gnt", lane_gnt_o, 4'b0001);
    cycle();
    lane_req_i = '0;
    chk("t1_ce", ce_rom_Occ_o, 1'b1);
    chk("t1_addr", addr_rom_Occ_o, 8'h12);
    chk("t1_busy", busy_o, 1'b1);
    cycle();
    chk("t1_ce_low", ce_rom_Occ_o, 1'b0);
    chk("t1_addr_hold", addr_rom_Occ_o, 8'h12);
    cycle();
    cycle();
    chk("t1_no_rsp_yet", lane_rsp_valid_o, 4'b0000);
    drive_valid(32'hDEADBEEF);
    cycle();
    data_Occ_i = 32'h0;
    chk("t1_rsp_valid", lane_rsp_valid_o, 4'b0001);
    chk("t1_rsp_data", lane_rsp_data_o, 32'hDEADBEEF);
    chk("t1_busy_done", busy_o, 1'b0);
    cycle();
    chk("t1_rsp_pulse", lane_rsp_valid_o, 4'b0000);
    chk("t1_data_hold", lane_rsp_data_o, 32'hDEADBEEF);

    // All lanes requesting, memory latency 2: grants 0,1,2,3,0,...
    do_reset();
    lane_addr_i = {8'h13, 8'h12, 8'h11, 8'h10};
    mem_auto    = 1'b1;
    lane_req_i  = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      #1;
      chk("t2_rr_gnt", lane_gnt_o, oh(g % N));
      cycle();
    end
    lane_req_i = '0;
    repeat (10) cycle();
    mem_auto = 1'b0;
    chk("t2_busy_idle", busy_o, 1'b0);
    chk("t2_rsp_left", exp_lane_q.size(), 0);

    // Stalled memory: four issues, then blocked until a pop frees a slot
    do_reset();
    ce_cnt      = 0;
    lane_addr_i = {8'h13, 8'h12, 8'h11, 8'h20};
    lane_req_i  = 4'b0001;
    for (int i = 0; i < MO; i++) begin
      #1;
      chk("t3_gnt_fill", lane_gnt_o, 4'b0001);
      cycle();
    end
    #1;
    chk("t3_gnt_full", lane_gnt_o, 4'b0000);
    chk("t3_busy", busy_o, 1'b1);
    cycle();
    cycle();
    chk("t3_ce_count", ce_cnt, MO);
    drive_valid(32'h1111_0001);
    #1;
    chk("t3_gnt_on_pop", lane_gnt_o, 4'b0001);
    cycle();
    chk("t3_ce_after_pop", ce_rom_Occ_o, 1'b1);
    chk("t3_rsp", lane_rsp_valid_o, 4'b0001);
    #1;
    chk("t3_still_full", lane_gnt_o, 4'b0000);
    lane_req_i = '0;
    for (int i = 0; i < MO; i++) begin
      drive_valid(32'h1111_0002 + DW'(i));
      cycle();
    end
    chk("t3_busy_done", busy_o, 1'b0);
    chk("t3_ce_total", ce_cnt, MO + 1);

    // Spurious response with nothing outstanding
    data_Occ_valid_i = 1'b1;
    data_Occ_i       = 32'h55;
    cycle();
    chk("t4_no_rsp", lane_rsp_valid_o, 4'b0000);
    chk("t4_err", err_spurious_o, 1'b1);
    chk("t4_data_hold", lane_rsp_data_o, last_data);
    cycle();
    cycle();
    chk("t4_err_sticky", err_spurious_o, 1'b1);

    // is_start dropped with two requests in flight
    lane_req_i = 4'b0110;
    #1;
    chk("t5_gnt1", lane_gnt_o, 4'b0010);
    cycle();
    lane_req_i = 4'b0100;
    #1;
    chk("t5_gnt2", lane_gnt_o, 4'b0100);
    cycle();
    is_start   = 1'b0;
    lane_req_i = 4'b0011;
    #1;
    chk("t5_gnt_blocked", lane_gnt_o, 4'b0000);
    chk("t5_busy", busy_o, 1'b1);
    drive_valid(32'hAAAA_0001);
    cycle();
    chk("t5_rsp1", lane_rsp_valid_o, 4'b0010);
    chk("t5_busy_mid", busy_o, 1'b1);
    #1;
    chk("t5_gnt_blocked2", lane_gnt_o, 4'b0000);
    drive_valid(32'hAAAA_0002);
    cycle();
    chk("t5_rsp2", lane_rsp_valid_o, 4'b0100);
    chk("t5_busy_off", busy_o, 1'b0);
    lane_req_i = '0;
    is_start   = 1'b1;

    // Reset with three outstanding, then spurious valid and pointer restart
    lane_req_i = 4'b1111;
    #1;
    chk("t6_gnt3", lane_gnt_o, 4'b1000);
    cycle();
    #1;
    chk("t6_gnt0", lane_gnt_o, 4'b0001);
    cycle();
    #1;
    chk("t6_gnt1", lane_gnt_o, 4'b0010);
    cycle();
    chk("t6_busy_before", busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_gnt_in_reset", lane_gnt_o, 4'b0000);
    cycle();
    lane_req_i = '0;
    chk("t6_ce", ce_rom_Occ_o, 1'b0);
    chk("t6_addr", addr_rom_Occ_o, 8'h00);
    chk("t6_rsp_valid", lane_rsp_valid_o, 4'b0000);
    chk("t6_rsp_data", lane_rsp_data_o, 32'h0);
    chk("t6_err", err_spurious_o, 1'b0);
    chk("t6_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    clear_sb();
    data_Occ_valid_i = 1'b1;
    data_Occ_i       = 32'h77;
    cycle();
    chk("t6_spurious_err", err_spurious_o, 1'b1);
    chk("t6_spurious_rsp", lane_rsp_valid_o, 4'b0000);
    lane_req_i = 4'b1111;
    #1;
    chk("t6_ptr_restart", lane_gnt_o, 4'b0001);
    cycle();
    lane_req_i = '0;
    drive_valid(32'hCAFE_0000);
    cycle();
    chk("t6_rsp", lane_rsp_valid_o, 4'b0001);
    chk("final_lane_q", exp_lane_q.size(), 0);
    chk("final_addr_q", exp_addr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
